alu_exec_sequencer: RTL and testbench

Multi-cycle controller that accepts one 16-bit instruction word at a time and sequences the ALU datapath for it. It decodes the register-type, shift-type and immediate-type formats into the op_code/instr_type pair consumed by alu_control, and selects the register-file read addresses and the B-operand source. It then times the register write-back and the PSR flag update. It sits between the instruction fetch path and the ALU, the alu_control block and the register file.

---
 rtl/alu_exec_sequencer_if.sv | 50 +++++
 rtl/alu_exec_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_sequencer_if
//  Purpose  : Bundles the instruction handshake, the alu_control/register-file
//             control outputs and the ALU carry return of alu_exec_sequencer.
//  Modports : master - instruction source / datapath side (drives instr,
//                      instr_valid, alu_carry)
//             slave  - the sequencer itself
//  Signals  : instr, instr_valid, instr_ready, op_code, instr_type,
//             rsrc_addr, rdest_addr, imm, imm_sel, reg_we, flags_we,
//             carry_in, alu_carry, busy, done, illegal
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_sequencer_if #(
    parameter int WIDTH_INSTR      = 16,
    parameter int WIDTH_OP_CODE    = 4,
    parameter int WIDTH_INSTR_TYPE = 1,
    parameter int WIDTH_REG_ADDR   = 4,
    parameter int WIDTH_IMM        = 8
);
    logic [WIDTH_INSTR-1:0]      instr;
    logic                        instr_valid;
    logic                        instr_ready;
    logic [WIDTH_OP_CODE-1:0]    op_code;
    logic [WIDTH_INSTR_TYPE-1:0] instr_type;
    logic [WIDTH_REG_ADDR-1:0]   rsrc_addr;
    logic [WIDTH_REG_ADDR-1:0]   rdest_addr;
    logic [WIDTH_IMM-1:0]        imm;
    logic                        imm_sel;
    logic                        reg_we;
    logic                        flags_we;
    logic                        carry_in;
    logic                        alu_carry;
    logic                        busy;
    logic                        done;
    logic                        illegal;

    modport master (
        output instr, instr_valid, alu_carry,
        input  instr_ready, op_code, instr_type, rsrc_addr, rdest_addr, imm,
               imm_sel, reg_we, flags_we, carry_in, busy, done, illegal
    );

    modport slave (
        input  instr, instr_valid, alu_carry,
        output instr_ready, op_code, instr_type, rsrc_addr, rdest_addr, imm,
               imm_sel, reg_we, flags_we, carry_in, busy, done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_sequencer
//  Purpose  : Multi-cycle controller for one 16-bit instruction at a time.
//             Decodes R-type / shift / immediate formats into op_code and
//             instr_type for alu_control, selects register-file addresses and
//             the B-operand source, and times write-back and PSR update.
//             Sequence: IDLE -> DECODE -> EXEC -> WB -> IDLE.
//  Ports    : clk   - system clock, rising edge
//             reset - synchronous, active-high
//             bus   - alu_exec_sequencer_if.slave (handshake + control)
//  Options  : ALU_SEQ_CARRY_CHAIN_EN - carry latch feeding carry_in for
//             ADDC/SUBC; when undefined carry_in is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_sequencer #(
    parameter int WIDTH_INSTR      = 16,
    parameter int WIDTH_OP_CODE    = 4,
    parameter int WIDTH_INSTR_TYPE = 1,
    parameter int WIDTH_REG_ADDR   = 4,
    parameter int WIDTH_IMM        = 8
) (
    input  wire                 clk,
    input  wire                 reset,
    alu_exec_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [3:0] c_fop_rtype = 4'b0000;
    localparam logic [3:0] c_fop_shift = 4'b1000;
    localparam logic [3:0] c_op_cmp    = 4'b1011;

    state_t r_state;
    state_t w_state_nxt;

    // The nine ALU operations valid as static op_codes (R-type ext or imm op).
    function automatic logic f_is_static(input logic [3:0] code);
        case (code)
            4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
            4'b0111, 4'b1001, 4'b1010, 4'b1011: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // ---------------------------------------------------------------- decode
    logic [3:0]                  w_f_op;
    logic [3:0]                  w_f_ext;
    logic                        w_legal;
    logic [WIDTH_OP_CODE-1:0]    w_op_code;
    logic [WIDTH_INSTR_TYPE-1:0] w_instr_type;
    logic                        w_imm_sel;

    assign w_f_op  = bus.instr[15:12];
    assign w_f_ext = bus.instr[7:4];

    always_comb begin
        w_legal      = 1'b0;
        w_op_code    = '0;
        w_instr_type = '0;
        w_imm_sel    = 1'b0;
        if (w_f_op == c_fop_rtype) begin
            w_legal   = f_is_static(w_f_ext);
            w_op_code = WIDTH_OP_CODE'(w_f_ext);
        end else if (w_f_op == c_fop_shift) begin
            w_legal      = (w_f_ext == 4'b0100) || (w_f_ext == 4'b0110);
            w_op_code    = WIDTH_OP_CODE'(w_f_ext);
            w_instr_type = WIDTH_INSTR_TYPE'(1);
        end else begin
            w_legal   = f_is_static(w_f_op);
            w_op_code = WIDTH_OP_CODE'(w_f_op);
            w_imm_sel = 1'b1;
        end
    end

    // ------------------------------------------------------- registered regs
    logic [WIDTH_OP_CODE-1:0]    r_op_code;
    logic [WIDTH_INSTR_TYPE-1:0] r_instr_type;
    logic [WIDTH_REG_ADDR-1:0]   r_rsrc_addr;
    logic [WIDTH_REG_ADDR-1:0]   r_rdest_addr;
    logic [WIDTH_IMM-1:0]        r_imm;
    logic                        r_imm_sel;
    logic                        r_legal;
    logic                        r_reg_we;
    logic                        r_flags_we;
    logic                        r_done;
    logic                        r_illegal;

    logic w_load;
    logic w_clear;
    logic w_reg_we_nxt;
    logic w_flags_we_nxt;
    logic w_done_nxt;
    logic w_illegal_nxt;
    logic w_is_cmp;

    assign w_is_cmp = (r_instr_type == '0) &&
                      (r_op_code == WIDTH_OP_CODE'(c_op_cmp));

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Write-back pulses are computed while in EXEC and registered so that
    // they appear exactly during the WB cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_clear        = 1'b0;
        w_reg_we_nxt   = 1'b0;
        w_flags_we_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_illegal_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    w_state_nxt = S_DECODE;
                    w_load      = 1'b1;
                end
            end
            S_DECODE: begin
                if (r_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt   = S_IDLE;
                    w_clear       = 1'b1;
                    w_illegal_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                end
            end
            S_EXEC: begin
                w_state_nxt    = S_WB;
                w_reg_we_nxt   = ~w_is_cmp;
                w_flags_we_nxt = 1'b1;
                w_done_nxt     = 1'b1;
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
                w_clear     = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_clear     = 1'b1;
            end
        endcase
    end

    // Control outputs are captured straight from the incoming word on the
    // accepting edge so they are valid throughout DECODE; an undecodable word
    // leaves them at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_code    <= '0;
            r_instr_type <= '0;
            r_rsrc_addr  <= '0;
            r_rdest_addr <= '0;
            r_imm        <= '0;
            r_imm_sel    <= 1'b0;
            r_legal      <= 1'b0;
            r_reg_we     <= 1'b0;
            r_flags_we   <= 1'b0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_reg_we   <= w_reg_we_nxt;
            r_flags_we <= w_flags_we_nxt;
            r_done     <= w_done_nxt;
            r_illegal  <= w_illegal_nxt;
            if (w_load) begin
                r_legal      <= w_legal;
                r_op_code    <= w_legal ? w_op_code : '0;
                r_instr_type <= w_legal ? w_instr_type : '0;
                r_rsrc_addr  <= w_legal ? WIDTH_REG_ADDR'(bus.instr[3:0]) : '0;
                r_rdest_addr <= w_legal ? WIDTH_REG_ADDR'(bus.instr[11:8]) : '0;
                r_imm        <= (w_legal && w_imm_sel) ? bus.instr[WIDTH_IMM-1:0] : '0;
                r_imm_sel    <= w_legal && w_imm_sel;
            end else if (w_clear) begin
                r_legal      <= 1'b0;
                r_op_code    <= '0;
                r_instr_type <= '0;
                r_rsrc_addr  <= '0;
                r_rdest_addr <= '0;
                r_imm        <= '0;
                r_imm_sel    <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------- carry chain
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    logic r_carry;
    logic w_is_arith;
    logic w_uses_carry;

    // ADD, ADDU, ADDC, SUB, SUBC as static ops (shift 0110 is not ADDU).
    assign w_is_arith = (r_instr_type == '0) &&
                        ((r_op_code == WIDTH_OP_CODE'(4'b0101)) ||
                         (r_op_code == WIDTH_OP_CODE'(4'b0110)) ||
                         (r_op_code == WIDTH_OP_CODE'(4'b0111)) ||
                         (r_op_code == WIDTH_OP_CODE'(4'b1001)) ||
                         (r_op_code == WIDTH_OP_CODE'(4'b1010)));

    assign w_uses_carry = (r_instr_type == '0) &&
                          ((r_op_code == WIDTH_OP_CODE'(4'b0111)) ||
                           (r_op_code == WIDTH_OP_CODE'(4'b1010)));

    always_ff @(posedge clk) begin
        if (reset)                               r_carry <= 1'b0;
        else if ((r_state == S_WB) && w_is_arith) r_carry <= bus.alu_carry;
    end

    assign bus.carry_in = (r_state != S_IDLE) && w_uses_carry && r_carry;
`else
    logic w_unused_alu_carry;
    assign w_unused_alu_carry = bus.alu_carry;
    assign bus.carry_in       = 1'b0;
`endif

    // -------------------------------------------------------------- outputs
    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.op_code     = r_op_code;
    assign bus.instr_type  = r_instr_type;
    assign bus.rsrc_addr   = r_rsrc_addr;
    assign bus.rdest_addr  = r_rdest_addr;
    assign bus.imm         = r_imm;
    assign bus.imm_sel     = r_imm_sel;
    assign bus.reg_we      = r_reg_we;
    assign bus.flags_we    = r_flags_we;
    assign bus.done        = r_done;
    assign bus.illegal     = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_sequencer
//  Purpose  : Self-checking bench for alu_exec_sequencer. A transaction-level
//             model (phase count since acceptance + table decode) predicts
//             every output each cycle; directed scenarios pin literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_exec_sequencer_if bus ();

    alu_exec_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------- model
    typedef struct packed {
        logic       legal;
        logic [3:0] op;
        logic       typ;
        logic [3:0] rs;
        logic [3:0] rd;
        logic [7:0] imm;
        logic       imm_sel;
    } dec_t;

    function automatic bit legal_code(input logic [3:0] c);
        logic [15:0] mask;
        mask = 16'h0EEE;    // bits 1,2,3,5,6,7,9,10,11
        return mask[c];
    endfunction

    function automatic dec_t decode(input logic [15:0] w);
        dec_t d;
        d = '0;
        if (w[15:12] == 4'h0)      d.legal = legal_code(w[7:4]);
        else if (w[15:12] == 4'h8) d.legal = (w[7:4] == 4'h4) || (w[7:4] == 4'h6);
        else                       d.legal = legal_code(w[15:12]);
        if (d.legal) begin
            d.rs = w[3:0];
            d.rd = w[11:8];
            if (w[15:12] == 4'h0) d.op = w[7:4];
            else if (w[15:12] == 4'h8) begin d.op = w[7:4]; d.typ = 1'b1; end
            else begin d.op = w[15:12]; d.imm = w[7:0]; d.imm_sel = 1'b1; end
        end
        return d;
    endfunction

    // m_phase: 0 idle, 1..3 = cycles since acceptance (decode, exec, wb)
    int          m_phase = 0;
    logic [15:0] m_instr = '0;
    bit          m_ill   = 1'b0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    bit          m_carry = 1'b0;
`endif

    always @(posedge clk) begin
        dec_t d;
        cyc++;
        checking = 1'b1;
        d = decode(m_instr);
        m_ill = 1'b0;
        if (reset) begin
            m_phase = 0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            m_carry = 1'b0;
`endif
        end else begin
            case (m_phase)
                0: if (bus.instr_valid) begin m_instr = bus.instr; m_phase = 1; end
                1: if (!d.legal) begin m_phase = 0; m_ill = 1'b1; end
                   else m_phase = 2;
                2: m_phase = 3;
                default: begin
`ifdef ALU_SEQ_CARRY_CHAIN_EN
                    if (!d.typ && (d.op inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA}))
                        m_carry = bus.alu_carry;
`endif
                    m_phase = 0;
                end
            endcase
        end
    end

    // Compare process: every cycle, every output.
    always @(negedge clk) begin
        dec_t d;
        bit   wb;
        bit   cin;
        if (checking) begin
            d   = (m_phase != 0) ? decode(m_instr) : '0;
            wb  = (m_phase == 3);
            cin = 1'b0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            cin = (m_phase != 0) && !d.typ && (d.op == 4'h7 || d.op == 4'hA) && m_carry;
`endif
            chk("instr_ready", bus.instr_ready, m_phase == 0);
            chk("busy",        bus.busy,        m_phase != 0);
            chk("op_code",     bus.op_code,     d.op);
            chk("instr_type",  bus.instr_type,  d.typ);
            chk("rsrc_addr",   bus.rsrc_addr,   d.rs);
            chk("rdest_addr",  bus.rdest_addr,  d.rd);
            chk("imm",         bus.imm,         d.imm);
            chk("imm_sel",     bus.imm_sel,     d.imm_sel);
            chk("reg_we",      bus.reg_we,      wb && !(d.op == 4'hB && !d.typ));
            chk("flags_we",    bus.flags_we,    wb);
            chk("done",        bus.done,        wb || m_ill);
            chk("illegal",     bus.illegal,     m_ill);
            chk("carry_in",    bus.carry_in,    cin);
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!bus.instr_ready && k < 10) begin step(); k++; end
        chk("idle_timeout", bus.instr_ready, 1'b1);
    endtask

    // Returns one step after the accepting edge (inside DECODE).
    task automatic send(input logic [15:0] w);
        wait_idle();
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        bus.instr       = 16'($urandom);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] imm_ops [9];
        imm_ops = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB};
        case ($urandom_range(0, 3))
            0:       return {4'h0, 4'($urandom), 4'($urandom), 4'($urandom)};
            1:       return {4'h8, 4'($urandom), (($urandom_range(0, 1) == 1) ? 4'h4 : 4'h6), 4'($urandom)};
            2:       return 16'($urandom);
            default: return {imm_ops[$urandom_range(0, 8)], 12'($urandom)};
        endcase
    endfunction

    initial begin
        logic [3:0] dop [2];
        int         dcy [2];
        int         nd;
        bit         any_pulse;
        bit         exp_cin;

        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.alu_carry   = 1'b0;
        reset           = 1'b1;
        step(); step();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", bus.instr_ready, 1'b1);
        chk("rst_busy",  bus.busy,        1'b0);
        chk("rst_op",    bus.op_code,     4'h0);
        chk("rst_done",  bus.done,        1'b0);

        // R-type ADD
        send(16'h0351);
        chk("add_op",    bus.op_code,    4'b0101);
        chk("add_type",  bus.instr_type, 1'b0);
        chk("add_rsrc",  bus.rsrc_addr,  4'd1);
        chk("add_rdest", bus.rdest_addr, 4'd3);
        step();
        chk("add_exec_we", bus.reg_we, 1'b0);
        step();
        chk("add_reg_we",   bus.reg_we,   1'b1);
        chk("add_flags_we", bus.flags_we, 1'b1);
        chk("add_done",     bus.done,     1'b1);
        step();
        chk("add_ready_after", bus.instr_ready, 1'b1);
        chk("add_done_once",   bus.done,        1'b0);

        // CMP immediate
        send(16'hB27F);
        chk("cmp_op",      bus.op_code, 4'b1011);
        chk("cmp_imm",     bus.imm,     8'h7F);
        chk("cmp_imm_sel", bus.imm_sel, 1'b1);
        step(); step();
        chk("cmp_reg_we",   bus.reg_we,   1'b0);
        chk("cmp_flags_we", bus.flags_we, 1'b1);
        chk("cmp_done",     bus.done,     1'b1);
        step();

        // Shift ALSHU, then an illegal shift extension
        send(16'h8462);
        chk("sh_op",    bus.op_code,    4'b0110);
        chk("sh_type",  bus.instr_type, 1'b1);
        chk("sh_rdest", bus.rdest_addr, 4'd4);
        chk("sh_rsrc",  bus.rsrc_addr,  4'd2);
        step(); step();
        chk("sh_reg_we", bus.reg_we, 1'b1);
        step();
        send(16'h84F2);
        step();
        chk("ill_illegal",  bus.illegal,  1'b1);
        chk("ill_done",     bus.done,     1'b1);
        chk("ill_reg_we",   bus.reg_we,   1'b0);
        chk("ill_flags_we", bus.flags_we, 1'b0);

        // Handshake stall: second word held valid while busy
        wait_idle();
        bus.instr       = 16'h0351;
        bus.instr_valid = 1'b1;
        step();
        bus.instr = 16'h1207;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                if (nd < 2) begin dop[nd] = bus.op_code; dcy[nd] = i; end
                nd++;
            end
            if (i == 6) bus.instr_valid = 1'b0;
            step();
        end
        chk("stall_count", 32'(nd), 32'd2);
        if (nd >= 2) begin
            chk("stall_first_op",  dop[0], 4'h5);
            chk("stall_second_op", dop[1], 4'h1);
            chk("stall_spacing",   32'(dcy[1] - dcy[0]), 32'd4);
        end

        // Reset asserted during EXEC
        send(16'h0152);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_ready", bus.instr_ready, 1'b1);
        chk("mrst_busy",  bus.busy,        1'b0);
        any_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            any_pulse |= bus.reg_we | bus.flags_we | bus.done;
            step();
        end
        chk("mrst_no_pulse", any_pulse, 1'b0);

        // Carry chain: ADD producing carry, then ADDC
`ifdef ALU_SEQ_CARRY_CHAIN_EN
        exp_cin = 1'b1;
`else
        exp_cin = 1'b0;
`endif
        bus.alu_carry = 1'b1;
        send(16'h0351);
        step(); step(); step();
        send(16'h0172);
        chk("addc_cin_dec", bus.carry_in, exp_cin);
        step();
        chk("addc_cin_exec", bus.carry_in, exp_cin);
        step();
        chk("addc_cin_wb", bus.carry_in, exp_cin);
        step();
        chk("addc_cin_idle", bus.carry_in, 1'b0);
        bus.alu_carry = 1'b0;

        // Randomized traffic, checked cycle-by-cycle by the model
        for (int i = 0; i < 3000; i++) begin
            bus.instr_valid = ($urandom_range(0, 2) != 0);
            bus.instr       = rand_instr();
            bus.alu_carry   = 1'($urandom);
            reset           = ($urandom_range(0, 79) == 0);
            step();
        end
        reset           = 1'b0;
        bus.instr_valid = 1'b0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
